// File: rtl/led_pkg.sv
// ============================================================================
// led_pkg : shared types and constants for the led_fader block
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package led_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } fade_state_t;

  localparam fade_state_t C_RESET_STATE = OFF;

endpackage

`default_nettype wire

// File: rtl/pwm_gen.sv
// ============================================================================
// pwm_gen : free-running PWM counter, period-wrap strobe, registered output
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic                i_full_on,
  output logic                o_wrap,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] r_cnt;
  logic                r_pwm;

  assign o_wrap = (r_cnt == {PWM_BITS{1'b1}});
  assign o_pwm  = r_pwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
      // full_on forces solid drive at max brightness, otherwise the top count would be lost
      r_pwm <= i_full_on | (r_cnt < i_duty);
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_fader.sv
// ============================================================================
// led_fader : PWM LED driver with linear brightness ramps on led_in edges
// Optional build macro LED_FADER_GAMMA_EN selects a squared duty curve.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module led_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                led_in,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int C_STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [C_STEP_W-1:0] C_STEP_LAST = C_STEP_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] C_MAX    = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] C_MAX_M1 = C_MAX - PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] C_ONE    = PWM_BITS'(1);

  logic                r_led_q;
  logic [C_STEP_W-1:0] r_step_cnt;
  fade_state_t         r_state;
  logic [PWM_BITS-1:0] r_level;
  logic                r_busy;

  logic                w_wrap;
  logic                w_tick;
  logic [PWM_BITS-1:0] w_duty;

  assign w_tick = w_wrap && (r_step_cnt == C_STEP_LAST);

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_lvl_ext;
  assign w_lvl_ext = {{PWM_BITS{1'b0}}, r_level};
  assign w_duty    = PWM_BITS'((w_lvl_ext * w_lvl_ext) >> PWM_BITS);
`else
  assign w_duty = r_level;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led_q    <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_led_q <= led_in;
      if (w_wrap) begin
        r_step_cnt <= (r_step_cnt == C_STEP_LAST) ? '0 : r_step_cnt + C_STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_RESET_STATE;
      r_level <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        OFF: begin
          if (r_led_q) begin
            r_state <= RISE;
            r_busy  <= 1'b1;
          end
        end
        ON: begin
          if (!r_led_q) begin
            r_state <= FALL;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          // Direction follows led_q on every cycle, including a tick cycle
          if (w_tick) begin
            if (r_led_q) begin
              if (r_level >= C_MAX_M1) begin
                r_level <= C_MAX;
                r_state <= ON;
                r_busy  <= 1'b0;
              end else begin
                r_level <= r_level + PWM_BITS'(1);
                r_state <= RISE;
              end
            end else begin
              if (r_level <= C_ONE) begin
                r_level <= '0;
                r_state <= OFF;
                r_busy  <= 1'b0;
              end else begin
                r_level <= r_level - PWM_BITS'(1);
                r_state <= FALL;
              end
            end
          end else begin
            r_state <= r_led_q ? RISE : FALL;
          end
        end
      endcase
    end
  end

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clk       (clk),
    .rst       (rst),
    .i_duty    (w_duty),
    .i_full_on (r_level == C_MAX),
    .o_wrap    (w_wrap),
    .o_pwm     (pwm_out)
  );

  assign level = r_level;
  assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_led_fader.sv
// ============================================================================
// tb_led_fader : self-checking bench for led_fader (PWM_BITS=4, STEP_CYCLES=2)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_led_fader;

  localparam int BITS   = 4;
  localparam int STEPS  = 2;
  localparam int MAXV   = (1 << BITS) - 1;
  localparam int PERIOD = 1 << BITS;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            led_in = 1'b1;
  logic            pwm_out;
  logic [BITS-1:0] level;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: brightness walks toward the led target once per step period
  int m_cyc  = 0;
  int m_lvl  = 0;
  int m_ramp = 0;
  int m_ledq = 0;
  int m_pwm  = 0;

  led_fader #(
    .PWM_BITS    (BITS),
    .STEP_CYCLES (STEPS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .led_in  (led_in),
    .pwm_out (pwm_out),
    .level   (level),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic int duty_of(input int l);
`ifdef LED_FADER_GAMMA_EN
    return (l * l) >> BITS;
`else
    return l;
`endif
  endfunction

  function automatic int tgt_of(input int q);
    return (q != 0) ? MAXV : 0;
  endfunction

  function automatic int step_toward(input int l, input int tgt);
    if (tgt > l) return l + 1;
    if (tgt < l) return l - 1;
    return l;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cyc  <= 0;
      m_lvl  <= 0;
      m_ramp <= 0;
      m_ledq <= 0;
      m_pwm  <= 0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_ledq <= int'(led_in);
      m_pwm  <= ((m_lvl == MAXV) || ((m_cyc % PERIOD) < duty_of(m_lvl))) ? 1 : 0;
      if (m_ramp == 0) begin
        if (m_lvl != tgt_of(m_ledq)) m_ramp <= 1;
      end else if ((m_cyc % (PERIOD * STEPS)) == PERIOD * STEPS - 1) begin
        m_lvl  <= step_toward(m_lvl, tgt_of(m_ledq));
        m_ramp <= (step_toward(m_lvl, tgt_of(m_ledq)) != tgt_of(m_ledq)) ? 1 : 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("level", 32'(level), m_lvl);
    chk("pwm_out", 32'(pwm_out), m_pwm);
    chk("busy", 32'(busy), m_ramp);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_lvl(input int tgt, input int budget, input string tag);
    int k = 0;
    while (level !== BITS'(tgt) && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(level), tgt);
  endtask

  initial begin
    int hi_cnt;
    int max_seen;
    int first_chg;
    int k;

    // reset held with led_in high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_level", 32'(level), 0);
      chk("rst_pwm", 32'(pwm_out), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    rst = 1'b0;
    run(2);
    chk("busy_after_release", 32'(busy), 1);

    // full rise, then solid on
    wait_lvl(MAXV, 600, "rise_to_max");
    step();
    for (int i = 0; i < 100; i++) begin
      step();
      chk("solid_on", 32'(pwm_out), 1);
      chk("on_busy", 32'(busy), 0);
    end

    // reversal at level 7
    led_in = 1'b0;
    wait_lvl(0, 600, "fall_to_zero");
    led_in = 1'b1;
    wait_lvl(7, 400, "rise_to_7");
    led_in    = 1'b0;
    max_seen  = 7;
    first_chg = -1;
    k = 0;
    while (level !== '0 && k < 600) begin
      step();
      if (int'(level) > max_seen) max_seen = int'(level);
      if (first_chg < 0 && int'(level) != 7) first_chg = int'(level);
      k++;
    end
    chk("rev_first_step", first_chg, 6);
    chk("rev_max_seen", max_seen, 7);
    chk("rev_end_level", 32'(level), 0);
    chk("rev_end_busy", 32'(busy), 0);

    // duty at level 5
    led_in = 1'b1;
    wait_lvl(5, 300, "rise_to_5");
    hi_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      hi_cnt += int'(pwm_out);
    end
    chk("duty_level5", hi_cnt, duty_of(5));

    // reset during a fall at level 9
    wait_lvl(MAXV, 400, "rise_again");
    led_in = 1'b0;
    wait_lvl(9, 400, "fall_to_9");
    rst = 1'b1;
    step();
    chk("midrst_level", 32'(level), 0);
    chk("midrst_pwm", 32'(pwm_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    rst    = 1'b0;
    led_in = 1'b1;
    wait_lvl(1, 80, "restart_from_0");

    // random led_in activity with occasional resets
    for (int s = 0; s < 16; s++) begin
      led_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      run(int'($urandom_range(1, 300)));
    end

    // idle with led_in low
    led_in = 1'b0;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      chk("idle_level", 32'(level), 0);
      chk("idle_pwm", 32'(pwm_out), 0);
      chk("idle_busy", 32'(busy), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
